// File: rtl/bpc_blk_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------------------------+
// | bpc_blk_packer: collects BPC code words and block sizes, emits header + words per block.    |
// | Rev 1.0                                                                                     |
// +--------------------------------------------------------------------------------------------+
module bpc_blk_packer #(
  parameter int WORD_W     = 64,
  parameter int SIZE_W     = 11,
  parameter int MAX_WORDS  = 8,
  parameter int DEPTH      = 16,
  parameter int META_DEPTH = 4,
  parameter int RAW_THRESH = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] data_i,
  input  logic              d_valid_i,
  input  logic [SIZE_W-1:0] size_i,
  input  logic              s_valid_i,
  output logic              ready_o,
  output logic [15:0]       hdr_o,
  output logic              hdr_valid_o,
  input  logic              hdr_ready_i,
  output logic [WORD_W-1:0] m_data_o,
  output logic              m_valid_o,
  output logic              m_last_o,
  input  logic              m_ready_i,
  output logic              ovf_o
);

  localparam int AW     = $clog2(DEPTH);
  localparam int MW     = $clog2(META_DEPTH);
  localparam int SZ_FLD = 10;
  localparam int WSH    = $clog2(WORD_W);

  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_DATA} state_t;

  logic [WORD_W-1:0] word_mem [DEPTH];
  logic [15:0]       meta_mem [META_DEPTH];

  logic [AW:0] w_wr_q, w_wr_d, w_rd_q, w_rd_d, w_cnt, w_cnt_d;
  logic [MW:0] mt_wr_q, mt_wr_d, mt_rd_q, mt_rd_d, mt_cnt, mt_cnt_d;
  logic [3:0]  wcnt_q, wcnt_d, wcnt_inc, blk_words;
  logic        ovf_q, ovf_d, ready_q, ready_d;
  logic        w_pop, mt_pop, w_push, mt_push;
  logic        hdr_raw, hdr_err;
  logic [SIZE_W:0]   ceil_w, exp_w;
  logic [SZ_FLD-1:0] size_fld;
  logic [15:0]       hdr_new;

  state_t            state_q;
  logic [3:0]        rem_q;
  logic              hdr_valid_q, m_valid_q, m_last_q;
  logic [15:0]       hdr_q;
  logic [WORD_W-1:0] m_data_q;

  assign w_cnt  = w_wr_q - w_rd_q;
  assign mt_cnt = mt_wr_q - mt_rd_q;
  assign w_pop  = m_valid_q && m_ready_i;
  assign mt_pop = hdr_valid_q && hdr_ready_i;

  // A pop in the same cycle frees the slot, so a full FIFO may still take the push.
  assign w_push  = d_valid_i && ((w_cnt != (AW+1)'(DEPTH)) || w_pop);
  assign mt_push = s_valid_i && ((mt_cnt != (MW+1)'(META_DEPTH)) || mt_pop);

  always_comb begin
    wcnt_inc  = (wcnt_q == 4'hF) ? 4'hF : wcnt_q + 4'd1;
    blk_words = d_valid_i ? wcnt_inc : wcnt_q;
    ceil_w    = ({1'b0, size_i} + (SIZE_W+1)'(WORD_W-1)) >> WSH;
    exp_w     = (ceil_w > (SIZE_W+1)'(MAX_WORDS)) ? (SIZE_W+1)'(MAX_WORDS) : ceil_w;
    hdr_raw   = (size_i >= SIZE_W'(RAW_THRESH));
    hdr_err   = ((SIZE_W+1)'(blk_words) != exp_w);
    // The 16-bit header leaves 10 bits for size; larger sizes saturate (raw is set for them anyway).
    size_fld  = ((size_i >> SZ_FLD) != '0) ? {SZ_FLD{1'b1}} : size_i[SZ_FLD-1:0];
    hdr_new   = {hdr_raw, hdr_err, blk_words, size_fld};
  end

  always_comb begin
    w_wr_d  = w_wr_q + (AW+1)'(w_push);
    w_rd_d  = w_rd_q + (AW+1)'(w_pop);
    mt_wr_d = mt_wr_q + (MW+1)'(mt_push);
    mt_rd_d = mt_rd_q + (MW+1)'(mt_pop);
    w_cnt_d  = w_wr_d - w_rd_d;
    mt_cnt_d = mt_wr_d - mt_rd_d;
    ready_d = (w_cnt_d <= (AW+1)'(DEPTH-2)) && (mt_cnt_d <= (MW+1)'(META_DEPTH-2));
    ovf_d   = ovf_q || (d_valid_i && !w_push) || (s_valid_i && !mt_push);
    wcnt_d  = wcnt_q;
    if (s_valid_i) begin
      wcnt_d = 4'd0;
    end else if (d_valid_i) begin
      wcnt_d = wcnt_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_wr_q  <= '0;
      w_rd_q  <= '0;
      mt_wr_q <= '0;
      mt_rd_q <= '0;
      wcnt_q  <= '0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      w_wr_q  <= w_wr_d;
      w_rd_q  <= w_rd_d;
      mt_wr_q <= mt_wr_d;
      mt_rd_q <= mt_rd_d;
      wcnt_q  <= wcnt_d;
      ovf_q   <= ovf_d;
      ready_q <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      word_mem[w_wr_q[AW-1:0]] <= data_i;
    end
    if (mt_push) begin
      meta_mem[mt_wr_q[MW-1:0]] <= hdr_new;
    end
  end

  // Egress: the word being offered stays in the FIFO until its handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rem_q       <= 4'd0;
      hdr_valid_q <= 1'b0;
      hdr_q       <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_data_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mt_cnt != '0) begin
            hdr_q       <= meta_mem[mt_rd_q[MW-1:0]];
            hdr_valid_q <= 1'b1;
            state_q     <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (hdr_ready_i) begin
            hdr_valid_q <= 1'b0;
            rem_q       <= hdr_q[13:10];
            state_q     <= (hdr_q[13:10] == 4'd0) ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_pop) begin
            if (rem_q == 4'd1) begin
              m_valid_q <= 1'b0;
              m_last_q  <= 1'b0;
              if (mt_cnt != '0) begin
                hdr_q       <= meta_mem[mt_rd_q[MW-1:0]];
                hdr_valid_q <= 1'b1;
                state_q     <= ST_HDR;
              end else begin
                state_q <= ST_IDLE;
              end
            end else begin
              rem_q <= rem_q - 4'd1;
              if (w_cnt > (AW+1)'(1)) begin
                m_data_q  <= word_mem[w_rd_q[AW-1:0] + AW'(1)];
                m_valid_q <= 1'b1;
                m_last_q  <= (rem_q == 4'd2);
              end else begin
                m_valid_q <= 1'b0;
                m_last_q  <= 1'b0;
              end
            end
          end else if (!m_valid_q && (w_cnt != '0)) begin
            m_data_q  <= word_mem[w_rd_q[AW-1:0]];
            m_valid_q <= 1'b1;
            m_last_q  <= (rem_q == 4'd1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ready_o     = ready_q;
  assign ovf_o       = ovf_q;
  assign hdr_o       = hdr_q;
  assign hdr_valid_o = hdr_valid_q;
  assign m_data_o    = m_data_q;
  assign m_valid_o   = m_valid_q;
  assign m_last_o    = m_last_q;

endmodule
`default_nettype wire

// File: tb/tb_bpc_blk_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------------------------+
// | tb_bpc_blk_packer: directed vector bench for bpc_blk_packer.                                |
// | Rev 1.0                                                                                     |
// +--------------------------------------------------------------------------------------------+
module tb_bpc_blk_packer;

  localparam int WORD_W = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic [WORD_W-1:0] data_i;
  logic              d_valid_i;
  logic [10:0]       size_i;
  logic              s_valid_i;
  logic              ready_o;
  logic [15:0]       hdr_o;
  logic              hdr_valid_o;
  logic              hdr_ready_i;
  logic [WORD_W-1:0] m_data_o;
  logic              m_valid_o;
  logic              m_last_o;
  logic              m_ready_i;
  logic              ovf_o;

  int checks = 0;
  int errors = 0;

  logic [15:0]       hdr_seen[$];
  logic [WORD_W-1:0] dat_seen[$];
  logic              last_seen[$];
  bit                saw_ready_low;

  bpc_blk_packer dut (
    .clk(clk), .rst(rst),
    .data_i(data_i), .d_valid_i(d_valid_i),
    .size_i(size_i), .s_valid_i(s_valid_i),
    .ready_o(ready_o),
    .hdr_o(hdr_o), .hdr_valid_o(hdr_valid_o), .hdr_ready_i(hdr_ready_i),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_last_o(m_last_o), .m_ready_i(m_ready_i),
    .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  // Inputs change just after posedge, so negedge values are what the next posedge sees.
  always @(negedge clk) begin
    if (!rst) begin
      if (hdr_valid_o && hdr_ready_i) hdr_seen.push_back(hdr_o);
      if (m_valid_o && m_ready_i) begin
        dat_seen.push_back(m_data_o);
        last_seen.push_back(m_last_o);
      end
      if (!ready_o) saw_ready_low = 1'b1;
    end
  end

  typedef struct {
    int          nw;
    bit          coinc;
    logic [10:0] size;
    logic [15:0] hdr;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [63:0] pat(input int b, input int w);
    return 64'hA5A5_0000_0000_0000 | (64'(b) << 16) | 64'(w);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] d, input bit dv, input bit sv, input logic [10:0] sz,
                      input bit honor_ready);
    if (honor_ready) begin
      int n = 0;
      while (!ready_o && n < 500) begin
        tick();
        n++;
      end
      if (!ready_o) begin
        checks++;
        errors++;
        $display("FAIL ready_timeout: ready_o got 0 expected 1");
      end
    end
    data_i    = d;
    d_valid_i = dv;
    s_valid_i = sv;
    size_i    = sz;
    tick();
    d_valid_i = 1'b0;
    s_valid_i = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_hdr_valid"}, 64'(hdr_valid_o), 64'd0);
    chk({tag, "_m_valid"},   64'(m_valid_o),   64'd0);
    chk({tag, "_m_last"},    64'(m_last_o),    64'd0);
    chk({tag, "_ovf"},       64'(ovf_o),       64'd0);
    chk({tag, "_ready"},     64'(ready_o),     64'd1);
    chk({tag, "_hdr"},       64'(hdr_o),       64'd0);
    chk({tag, "_m_data"},    m_data_o,         64'd0);
  endtask

  task automatic clear_seen();
    hdr_seen.delete();
    dat_seen.delete();
    last_seen.delete();
  endtask

  // One block with both sinks ready: push, drain, compare header and every word.
  task automatic run_block(input int b, input vec_t v);
    int n = 0;
    clear_seen();
    hdr_ready_i = 1'b1;
    m_ready_i   = 1'b1;
    for (int w = 0; w < v.nw; w++) push(pat(b, w), 1'b1, v.coinc && (w == v.nw - 1), v.size, 1'b1);
    if (!v.coinc || v.nw == 0) push('0, 1'b0, 1'b1, v.size, 1'b1);
    while ((hdr_seen.size() < 1 || dat_seen.size() < v.nw) && n < 200) begin
      tick();
      n++;
    end
    repeat (5) tick();
    chk($sformatf("v%0d_hdr_count", b), 64'(hdr_seen.size()), 64'd1);
    chk($sformatf("v%0d_word_count", b), 64'(dat_seen.size()), 64'(v.nw));
    if (hdr_seen.size() >= 1) chk($sformatf("v%0d_hdr", b), 64'(hdr_seen[0]), 64'(v.hdr));
    for (int i = 0; i < v.nw && i < dat_seen.size(); i++) begin
      chk($sformatf("v%0d_data%0d", b, i), dat_seen[i], pat(b, i));
      chk($sformatf("v%0d_last%0d", b, i), 64'(last_seen[i]), 64'(i == v.nw - 1));
    end
    chk($sformatf("v%0d_idle", b), 64'({hdr_valid_o, m_valid_o}), 64'd0);
    chk($sformatf("v%0d_ovf", b), 64'(ovf_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Header layout: {raw, err, words[3:0], size[9:0]}.
    vecs[0] = '{nw: 3, coinc: 1'b1, size: 11'd150,  hdr: {1'b0, 1'b0, 4'd3, 10'd150}};
    vecs[1] = '{nw: 8, coinc: 1'b0, size: 11'd530,  hdr: {1'b1, 1'b0, 4'd8, 10'd530}};
    vecs[2] = '{nw: 0, coinc: 1'b0, size: 11'd0,    hdr: {1'b0, 1'b0, 4'd0, 10'd0}};
    vecs[3] = '{nw: 2, coinc: 1'b0, size: 11'd200,  hdr: {1'b0, 1'b1, 4'd2, 10'd200}};
    vecs[4] = '{nw: 1, coinc: 1'b1, size: 11'd64,   hdr: {1'b0, 1'b0, 4'd1, 10'd64}};
    vecs[5] = '{nw: 5, coinc: 1'b1, size: 11'd257,  hdr: {1'b0, 1'b0, 4'd5, 10'd257}};
    vecs[6] = '{nw: 8, coinc: 1'b1, size: 11'd511,  hdr: {1'b0, 1'b0, 4'd8, 10'd511}};
    vecs[7] = '{nw: 1, coinc: 1'b0, size: 11'd1500, hdr: {1'b1, 1'b1, 4'd1, 10'd1023}};

    rst = 1'b1; data_i = '0; d_valid_i = 1'b0; size_i = '0; s_valid_i = 1'b0;
    hdr_ready_i = 1'b0; m_ready_i = 1'b0;
    repeat (3) tick();
    chk_reset("reset");
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) run_block(i, vecs[i]);

    // Backpressure: three full blocks against a stalled word sink.
    clear_seen();
    saw_ready_low = 1'b0;
    hdr_ready_i = 1'b1;
    m_ready_i   = 1'b0;
    fork
      begin
        for (int b = 0; b < 3; b++)
          for (int w = 0; w < 8; w++) push(pat(20 + b, w), 1'b1, w == 7, 11'd512, 1'b1);
      end
      begin
        repeat (40) tick();
        m_ready_i = 1'b1;
      end
    join
    n = 0;
    while (dat_seen.size() < 24 && n < 500) begin
      tick();
      n++;
    end
    repeat (5) tick();
    chk("bp_ready_dropped", 64'(saw_ready_low), 64'd1);
    chk("bp_ovf", 64'(ovf_o), 64'd0);
    chk("bp_hdr_count", 64'(hdr_seen.size()), 64'd3);
    chk("bp_word_count", 64'(dat_seen.size()), 64'd24);
    for (int i = 0; i < hdr_seen.size() && i < 3; i++)
      chk($sformatf("bp_hdr%0d", i), 64'(hdr_seen[i]), 64'({1'b1, 1'b0, 4'd8, 10'd512}));
    for (int i = 0; i < dat_seen.size() && i < 24; i++) begin
      chk($sformatf("bp_data%0d", i), dat_seen[i], pat(20 + i / 8, i % 8));
      chk($sformatf("bp_last%0d", i), 64'(last_seen[i]), 64'((i % 8) == 7));
    end

    // Overflow: 16 words fill the FIFO, the 17th is dropped.
    hdr_ready_i = 1'b0;
    m_ready_i   = 1'b0;
    for (int w = 0; w < 16; w++) push(pat(40, w), 1'b1, 1'b0, 11'd0, 1'b0);
    chk("ovf_before_full_push", 64'(ovf_o), 64'd0);
    chk("ovf_ready_when_full", 64'(ready_o), 64'd0);
    push(pat(40, 16), 1'b1, 1'b0, 11'd0, 1'b0);
    chk("ovf_set", 64'(ovf_o), 64'd1);
    repeat (5) tick();
    chk("ovf_sticky", 64'(ovf_o), 64'd1);
    rst = 1'b1;
    tick();
    chk_reset("ovf_rst");
    rst = 1'b0;
    tick();

    // Reset while a block is being offered.
    clear_seen();
    hdr_ready_i = 1'b1;
    m_ready_i   = 1'b0;
    for (int w = 0; w < 3; w++) push(pat(50, w), 1'b1, w == 2, 11'd150, 1'b1);
    n = 0;
    while (!m_valid_o && n < 50) begin
      tick();
      n++;
    end
    chk("mid_data_valid", 64'(m_valid_o), 64'd1);
    rst = 1'b1;
    tick();
    chk_reset("mid_rst");
    rst = 1'b0;
    tick();
    run_block(60, vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
